// File: rtl/saturn_field_pkg.sv
// Saturn field selector codes and the selector -> (start, last, wrap, err) decoder
// shared by the field masker pipeline.
package saturn_field_pkg;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned ARG_W = 8;
  localparam int unsigned EXT_W = ARG_W + 1;

  localparam logic [3:0] FLD_P        = 4'd0;
  localparam logic [3:0] FLD_WP       = 4'd1;
  localparam logic [3:0] FLD_XS       = 4'd2;
  localparam logic [3:0] FLD_X        = 4'd3;
  localparam logic [3:0] FLD_S        = 4'd4;
  localparam logic [3:0] FLD_M        = 4'd5;
  localparam logic [3:0] FLD_B        = 4'd6;
  localparam logic [3:0] FLD_W        = 4'd7;
  localparam logic [3:0] FLD_A        = 4'd8;
  localparam logic [3:0] FLD_EXPLICIT = 4'd9;

  // kill forces an empty mask; err may also be set with a live (clamped) mask
  typedef struct packed {
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] last;
    logic             wrap;
    logic             kill;
    logic             err;
  } fld_dec_t;

  function automatic fld_dec_t fld_decode(input logic [3:0]       code,
                                          input logic [ARG_W-1:0] p,
                                          input logic [ARG_W-1:0] st,
                                          input logic [ARG_W-1:0] len,
                                          input int unsigned      nib,
                                          input logic             wrap_en);
    fld_dec_t         d;
    logic [ARG_W-1:0] top;
    logic [EXT_W-1:0] e;
    logic [EXT_W-1:0] over;
    d    = '0;
    top  = ARG_W'(nib - 1);
    e    = {1'b0, st} + {1'b0, len};
    over = e - EXT_W'(nib);
    case (code)
      FLD_P: begin
        if (p > top) begin
          d.kill = 1'b1;
          d.err  = 1'b1;
        end else begin
          d.start = IDX_W'(p);
          d.last  = IDX_W'(p);
        end
      end
      FLD_WP: begin
        if (p > top) begin
          d.kill = 1'b1;
          d.err  = 1'b1;
        end else begin
          d.last = IDX_W'(p);
        end
      end
      FLD_XS: begin
        d.start = IDX_W'(2);
        d.last  = IDX_W'(2);
      end
      FLD_X: d.last = IDX_W'(2);
      FLD_S: begin
        d.start = IDX_W'(top);
        d.last  = IDX_W'(top);
      end
      FLD_M: begin
        d.start = IDX_W'(3);
        d.last  = IDX_W'(top - ARG_W'(1));
      end
      FLD_B: d.last = IDX_W'(1);
      FLD_W: d.last = IDX_W'(top);
      FLD_A: d.last = IDX_W'(4);
      FLD_EXPLICIT: begin
        if (st > top) begin
          d.kill = 1'b1;
          d.err  = 1'b1;
        end else begin
          d.start = IDX_W'(st);
          if (e > {1'b0, top}) begin
            if (wrap_en) begin
              // a wrap tail longer than the register simply covers everything
              d.wrap = 1'b1;
              d.last = (over > {1'b0, top}) ? IDX_W'(top) : IDX_W'(over);
            end else begin
              d.last = IDX_W'(top);
              d.err  = 1'b1;
            end
          end else begin
            d.last = IDX_W'(e);
          end
        end
      end
      default: begin
        d.kill = 1'b1;
        d.err  = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/saturn_field_masker_if.sv
// Request/result handshake bundle between decoder, field masker and write path.
interface saturn_field_masker_if #(
  parameter int unsigned NIBBLES = 16,
  parameter int unsigned PW      = 4
);
  localparam int unsigned DW = 4 * NIBBLES;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_field;
  logic [PW-1:0] in_p;
  logic [PW-1:0] in_start;
  logic [PW-1:0] in_len;
  logic [DW-1:0] in_dst;
  logic [DW-1:0] in_src;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_mask;
  logic [DW-1:0] out_data;
  logic          out_err;

  modport master (
    output in_valid, in_field, in_p, in_start, in_len, in_dst, in_src, out_ready,
    input  in_ready, out_valid, out_mask, out_data, out_err
  );

  modport slave (
    input  in_valid, in_field, in_p, in_start, in_len, in_dst, in_src, out_ready,
    output in_ready, out_valid, out_mask, out_data, out_err
  );
endinterface

// File: rtl/saturn_nibble_mask.sv
// Expands an inclusive (optionally wrapping) nibble range into a 4-bit-per-nibble mask.
module saturn_nibble_mask
  import saturn_field_pkg::*;
#(
  parameter int unsigned NIBBLES = 16
) (
  input  logic [IDX_W-1:0]     start,
  input  logic [IDX_W-1:0]     last,
  input  logic                 wrap,
  output logic [4*NIBBLES-1:0] mask_c
);

  logic [IDX_W-1:0] idx_c;
  logic             hit_c;

  always_comb begin
    mask_c = '0;
    idx_c  = '0;
    hit_c  = 1'b0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      idx_c = IDX_W'(i);
      hit_c = wrap ? ((idx_c >= start) || (idx_c <= last))
                   : ((idx_c >= start) && (idx_c <= last));
      mask_c[4*i +: 4] = {4{hit_c}};
    end
  end

endmodule

// File: rtl/saturn_field_masker.sv
// Two-stage field masker: S1 decodes the selector, S2 builds the mask and merges
// src into dst. Elastic valid/ready on both ends, one result per cycle.
module saturn_field_masker
  import saturn_field_pkg::*;
#(
  parameter int unsigned NIBBLES = 16,
  parameter int unsigned PW      = 4,
  parameter bit          WRAP_EN = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  saturn_field_masker_if.slave bus
);

  localparam int unsigned DW = 4 * NIBBLES;

  logic          s1_valid_d, s1_valid_q;
  fld_dec_t      s1_dec_d,   s1_dec_q;
  logic [DW-1:0] s1_dst_d,   s1_dst_q;
  logic [DW-1:0] s1_src_d,   s1_src_q;
  logic          out_valid_d, out_valid_q;
  logic [DW-1:0] out_mask_d,  out_mask_q;
  logic [DW-1:0] out_data_d,  out_data_q;
  logic          out_err_d,   out_err_q;

  logic          s2_adv_c;
  logic          s1_adv_c;
  logic [DW-1:0] raw_mask_c;
  logic [DW-1:0] mask_c;

  saturn_nibble_mask #(.NIBBLES(NIBBLES)) u_mask (
    .start  (s1_dec_q.start),
    .last   (s1_dec_q.last),
    .wrap   (s1_dec_q.wrap),
    .mask_c (raw_mask_c)
  );

  // Stage advance depends only on registered state and out_ready, never on in_valid
  always_comb begin
    s2_adv_c    = !out_valid_q || bus.out_ready;
    s1_adv_c    = !s1_valid_q || s2_adv_c;
    mask_c      = s1_dec_q.kill ? '0 : raw_mask_c;

    s1_valid_d  = s1_valid_q;
    s1_dec_d    = s1_dec_q;
    s1_dst_d    = s1_dst_q;
    s1_src_d    = s1_src_q;
    out_valid_d = out_valid_q;
    out_mask_d  = out_mask_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;

    if (s2_adv_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_mask_d = mask_c;
        out_data_d = (s1_src_q & mask_c) | (s1_dst_q & ~mask_c);
        out_err_d  = s1_dec_q.err;
      end
    end

    if (s1_adv_c) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_dec_d = fld_decode(bus.in_field, ARG_W'(bus.in_p), ARG_W'(bus.in_start),
                              ARG_W'(bus.in_len), NIBBLES, WRAP_EN);
        s1_dst_d = bus.in_dst;
        s1_src_d = bus.in_src;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_dec_q    <= '0;
      s1_dst_q    <= '0;
      s1_src_q    <= '0;
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_dec_q    <= s1_dec_d;
      s1_dst_q    <= s1_dst_d;
      s1_src_q    <= s1_src_d;
      out_valid_q <= out_valid_d;
      out_mask_q  <= out_mask_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.in_ready  = s1_adv_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_saturn_field_masker.sv
// Bench: a wrapping and a clamping masker share one stimulus stream and are both
// checked against a nibble-set reference model.
module tb_saturn_field_masker;

  localparam int unsigned N  = 16;
  localparam int unsigned PW = 4;
  localparam int unsigned DW = 4 * N;
  localparam int          NT = 300;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  saturn_field_masker_if #(.NIBBLES(N), .PW(PW)) bus_w ();
  saturn_field_masker_if #(.NIBBLES(N), .PW(PW)) bus_c ();

  assign bus_c.in_valid  = bus_w.in_valid;
  assign bus_c.in_field  = bus_w.in_field;
  assign bus_c.in_p      = bus_w.in_p;
  assign bus_c.in_start  = bus_w.in_start;
  assign bus_c.in_len    = bus_w.in_len;
  assign bus_c.in_dst    = bus_w.in_dst;
  assign bus_c.in_src    = bus_w.in_src;
  assign bus_c.out_ready = bus_w.out_ready;

  saturn_field_masker #(.NIBBLES(N), .PW(PW), .WRAP_EN(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(bus_w));
  saturn_field_masker #(.NIBBLES(N), .PW(PW), .WRAP_EN(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c));

  typedef struct packed {
    logic [DW-1:0] mask;
    logic [DW-1:0] data;
    logic          err;
  } res_t;

  typedef struct packed {
    res_t w;
    res_t c;
  } exp_t;

  // Reference: collect the selected nibble indices, then build mask and merge
  function automatic res_t model(input logic [3:0] code, input int p, input int st,
                                 input int ln, input logic [DW-1:0] dst,
                                 input logic [DW-1:0] src, input bit wrap);
    bit   sel[N];
    res_t r;
    int   idx;
    r = '0;
    for (int i = 0; i < N; i++) sel[i] = 1'b0;
    case (code)
      4'd0: if (p < N) sel[p] = 1'b1; else r.err = 1'b1;
      4'd1: if (p < N) for (int i = 0; i <= p; i++) sel[i] = 1'b1; else r.err = 1'b1;
      4'd2: sel[2] = 1'b1;
      4'd3: for (int i = 0; i <= 2; i++) sel[i] = 1'b1;
      4'd4: sel[N-1] = 1'b1;
      4'd5: for (int i = 3; i <= N - 2; i++) sel[i] = 1'b1;
      4'd6: for (int i = 0; i <= 1; i++) sel[i] = 1'b1;
      4'd7: for (int i = 0; i < N; i++) sel[i] = 1'b1;
      4'd8: for (int i = 0; i <= 4; i++) sel[i] = 1'b1;
      4'd9: begin
        if (st >= N) r.err = 1'b1;
        else begin
          for (int k = 0; k <= ln; k++) begin
            idx = st + k;
            if (idx < N) sel[idx] = 1'b1;
            else if (wrap) sel[idx - N] = 1'b1;
            else r.err = 1'b1;
          end
        end
      end
      default: r.err = 1'b1;
    endcase
    for (int i = 0; i < N; i++) if (sel[i]) r.mask[4*i +: 4] = 4'hF;
    r.data = (src & r.mask) | (dst & ~r.mask);
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive(input logic [3:0] code, input int p, input int st, input int ln,
                       input logic [DW-1:0] dst, input logic [DW-1:0] src);
    bus_w.in_valid = 1'b1;
    bus_w.in_field = code;
    bus_w.in_p     = PW'(p);
    bus_w.in_start = PW'(st);
    bus_w.in_len   = PW'(ln);
    bus_w.in_dst   = dst;
    bus_w.in_src   = src;
  endtask

  // One isolated transaction with out_ready high; reports both results and latency
  task automatic xact(input logic [3:0] code, input int p, input int st, input int ln,
                      input logic [DW-1:0] dst, input logic [DW-1:0] src,
                      output bit ok, output res_t rw, output res_t rc, output int lat);
    bit acc;
    int n;
    ok = 1'b0; lat = 0; rw = '0; rc = '0; n = 0;
    bus_w.out_ready = 1'b1;
    drive(code, p, st, ln, dst, src);
    do begin
      @(negedge clk);
      n++;
      acc = bus_w.in_ready;
      @(posedge clk); #1;
    end while (!acc && n < 20);
    bus_w.in_valid = 1'b0;
    if (!acc) return;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus_w.out_valid && lat < 20);
    if (bus_w.out_valid) begin
      ok = 1'b1;
      rw.mask = bus_w.out_mask; rw.data = bus_w.out_data; rw.err = bus_w.out_err;
      rc.mask = bus_c.out_mask; rc.data = bus_c.out_data; rc.err = bus_c.out_err;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus_w.out_valid, bus_c.out_valid, bus_w.out_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_valid_err: got %b want 000",
                         {bus_w.out_valid, bus_c.out_valid, bus_w.out_err});
    end
    n_tests++;
    if ({bus_w.out_mask, bus_w.out_data} !== '0) begin
      n_fail++; $display("FAIL reset_mask_data: got %h %h want 0", bus_w.out_mask, bus_w.out_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus_w.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus_w.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_word();
    bit ok; res_t rw, rc; int lat;
    xact(4'd7, 0, 0, 0, '0, {DW{1'b1}}, ok, rw, rc, lat);
    n_tests++;
    if (!ok || lat != 2) begin
      n_fail++; $display("FAIL w_latency: got ok=%0d lat=%0d want ok=1 lat=2", ok, lat);
    end
    n_tests++;
    if (rw !== {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0}) begin
      n_fail++; $display("FAIL w_field: got %h %h %b want all-F all-F 0", rw.mask, rw.data, rw.err);
    end
    n_tests++;
    if (rc !== rw) begin
      n_fail++; $display("FAIL w_field_clamp_dut: got %h %b want %h 0", rc.mask, rc.err, rw.mask);
    end
  endtask

  task automatic test_wp();
    bit ok; res_t rw, rc; int lat;
    xact(4'd1, 5, 0, 0, 64'h1111_1111_1111_1111, 64'hAAAA_AAAA_AAAA_AAAA, ok, rw, rc, lat);
    n_tests++;
    if (!ok || rw !== {64'h0000_0000_00FF_FFFF, 64'h1111_1111_11AA_AAAA, 1'b0}) begin
      n_fail++; $display("FAIL wp_field: got ok=%0d %h %h %b want 00000000_00FFFFFF 11111111_11AAAAAA 0",
                         ok, rw.mask, rw.data, rw.err);
    end
  endtask

  task automatic test_explicit();
    bit ok; res_t rw, rc; int lat;
    logic [DW-1:0] dst, src;
    dst = rnd64(); src = rnd64();
    xact(4'd9, 0, 14, 3, dst, src, ok, rw, rc, lat);
    n_tests++;
    if (!ok || rw.mask !== 64'hFF00_0000_0000_00FF || rw.err !== 1'b0) begin
      n_fail++; $display("FAIL explicit_wrap: got %h err=%b want ff000000000000ff err=0", rw.mask, rw.err);
    end
    n_tests++;
    if (rw.data !== ((src & 64'hFF00_0000_0000_00FF) | (dst & ~64'hFF00_0000_0000_00FF))) begin
      n_fail++; $display("FAIL explicit_wrap_data: got %h", rw.data);
    end
    n_tests++;
    if (rc.mask !== 64'hFF00_0000_0000_0000 || rc.err !== 1'b1) begin
      n_fail++; $display("FAIL explicit_clamp: got %h err=%b want ff00000000000000 err=1", rc.mask, rc.err);
    end
  endtask

  task automatic test_illegal();
    bit ok; res_t rw, rc; int lat;
    xact(4'd12, 3, 2, 1, 64'h1234_5678_9ABC_DEF0, rnd64(), ok, rw, rc, lat);
    n_tests++;
    if (!ok || rw !== {64'h0, 64'h1234_5678_9ABC_DEF0, 1'b1} || rc !== rw) begin
      n_fail++; $display("FAIL illegal_code: got %h %h %b want 0 123456789abcdef0 1", rw.mask, rw.data, rw.err);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]    cd[3];
    logic [DW-1:0] em[3], ds[3], ss[3];
    logic [DW-1:0] held;
    cd[0] = 4'd2; cd[1] = 4'd3; cd[2] = 4'd6;
    em[0] = 64'h0F00; em[1] = 64'h0FFF; em[2] = 64'h00FF;
    for (int i = 0; i < 3; i++) begin ds[i] = rnd64(); ss[i] = rnd64(); end
    bus_w.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(cd[i], 0, 0, 0, ds[i], ss[i]);
      @(negedge clk);
      n_tests++;
      if (bus_w.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL bp_accept%0d: in_ready got %b want 1", i, bus_w.in_ready);
      end
      @(posedge clk); #1;
    end
    drive(cd[2], 0, 0, 0, ds[2], ss[2]);
    @(negedge clk);
    held = bus_w.out_data;
    n_tests++;
    if ({bus_w.in_ready, bus_w.out_valid} !== 2'b01 || bus_w.out_mask !== em[0]) begin
      n_fail++; $display("FAIL bp_stall: ready/valid %b mask %h want 01 %h",
                         {bus_w.in_ready, bus_w.out_valid}, bus_w.out_mask, em[0]);
    end
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++;
      if (bus_w.in_ready !== 1'b0 || bus_w.out_mask !== em[0] || bus_w.out_data !== held) begin
        n_fail++; $display("FAIL bp_hold: ready %b mask %h data %h want 0 %h %h",
                           bus_w.in_ready, bus_w.out_mask, bus_w.out_data, em[0], held);
      end
    end
    @(posedge clk); #1 bus_w.out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus_w.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_drain_accept: in_ready got %b want 1", bus_w.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); end
      n_tests++;
      if (bus_w.out_valid !== 1'b1 || bus_w.out_mask !== em[i] || bus_w.out_err !== 1'b0 ||
          bus_w.out_data !== ((ss[i] & em[i]) | (ds[i] & ~em[i]))) begin
        n_fail++; $display("FAIL bp_out%0d: valid %b mask %h data %h want 1 %h", i,
                           bus_w.out_valid, bus_w.out_mask, bus_w.out_data, em[i]);
      end
      @(posedge clk); #1 bus_w.in_valid = 1'b0;
    end
    @(negedge clk);
    n_tests++;
    if (bus_w.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_empty: out_valid got %b want 0", bus_w.out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_stream();
    exp_t q[$];
    int   sent = 0, got = 0, cyc = 0;
    fork
      begin : drv
        logic [3:0] code; int p, st, ln; logic [DW-1:0] dst, src; bit have;
        have = 1'b0; code = '0; p = 0; st = 0; ln = 0; dst = '0; src = '0;
        while (sent < NT && cyc < 5000) begin
          if (!have) begin
            code = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 9));
            p = $urandom_range(0, N - 1); st = $urandom_range(0, 15); ln = $urandom_range(0, 15);
            dst = rnd64(); src = rnd64(); have = 1'b1;
          end
          drive(code, p, st, ln, dst, src);
          bus_w.in_valid = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (bus_w.in_valid && bus_w.in_ready) begin
            q.push_back({model(code, p, st, ln, dst, src, 1'b1),
                         model(code, p, st, ln, dst, src, 1'b0)});
            sent++; have = 1'b0;
          end
          @(posedge clk); #1;
        end
        bus_w.in_valid = 1'b0;
      end
      begin : mon
        exp_t e; res_t ow, oc;
        while (got < NT && cyc < 5000) begin
          bus_w.out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          cyc++;
          if (bus_w.out_valid && bus_w.out_ready) begin
            ow.mask = bus_w.out_mask; ow.data = bus_w.out_data; ow.err = bus_w.out_err;
            oc.mask = bus_c.out_mask; oc.data = bus_c.out_data; oc.err = bus_c.out_err;
            n_tests++;
            if (q.size() == 0) begin
              n_fail++; $display("FAIL rnd_spurious: got output %h with nothing pending", ow.mask);
            end else begin
              e = q.pop_front();
              if (ow !== e.w) begin
                n_fail++; $display("FAIL rnd_wrap #%0d: got %h %h %b want %h %h %b", got,
                                   ow.mask, ow.data, ow.err, e.w.mask, e.w.data, e.w.err);
              end
              n_tests++;
              if (oc !== e.c) begin
                n_fail++; $display("FAIL rnd_clamp #%0d: got %h %h %b want %h %h %b", got,
                                   oc.mask, oc.data, oc.err, e.c.mask, e.c.data, e.c.err);
              end
            end
            got++;
          end
          @(posedge clk); #1;
        end
      end
    join
    n_tests++;
    if (got != NT) begin
      n_fail++; $display("FAIL rnd_count: got %0d results want %0d", got, NT);
    end
    bus_w.out_ready = 1'b1;
  endtask

  task automatic test_reset_inflight();
    bus_w.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(4'd7, 0, 0, 0, rnd64(), rnd64());
      @(negedge clk);
      @(posedge clk); #1;
    end
    bus_w.in_valid = 1'b0;
    n_tests++;
    if (bus_w.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: out_valid got %b want 1", bus_w.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus_w.out_valid, bus_c.out_valid, bus_w.out_err} !== 3'b000 ||
        {bus_w.out_mask, bus_w.out_data} !== '0) begin
      n_fail++; $display("FAIL rst_async: valid %b mask %h data %h want 0",
                         bus_w.out_valid, bus_w.out_mask, bus_w.out_data);
    end
    @(posedge clk); #1 rst_n = 1'b1; bus_w.out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_tests++;
      if ({bus_w.out_valid, bus_c.out_valid, bus_w.in_ready} !== 3'b001) begin
        n_fail++; $display("FAIL rst_no_stale: valid_w/valid_c/in_ready got %b want 001",
                           {bus_w.out_valid, bus_c.out_valid, bus_w.in_ready});
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus_w.in_valid = 1'b0; bus_w.in_field = '0; bus_w.in_p = '0; bus_w.in_start = '0;
    bus_w.in_len = '0; bus_w.in_dst = '0; bus_w.in_src = '0; bus_w.out_ready = 1'b1;
    test_reset();
    test_full_word();
    test_wp();
    test_explicit();
    test_illegal();
    test_backpressure();
    test_random_stream();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/saturn_field_masker.md
Name: saturn_field_masker

Overview:
- Parametrised, pipelined successor to the nibble mask generator.
- Decodes a Saturn field selector into a nibble-granular mask: P, WP, XS, X, S, M, B, W, A, or an explicit start/length.
- Merges a source register into a destination register under that mask.
- Sits between the instruction decoder and the ALU/register-file write path; valid/ready handshakes on both sides.

Parameters:
- NIBBLES, 16, register width in nibbles; legal range 8..16.
- PW, 4, pointer/start/length width; must satisfy 2**PW >= NIBBLES.
- WRAP_EN, 1: 1 = explicit fields wrap modulo NIBBLES; 0 = clamp at NIBBLES-1 and flag an error.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_field  in  4  field code (see Behaviour).
- in_p  in  PW  P pointer register value.
- in_start  in  PW  explicit start nibble (code 9 only).
- in_len  in  PW  explicit length minus one (code 9 only).
- in_dst  in  4*NIBBLES  destination register value.
- in_src  in  4*NIBBLES  source value.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_mask  out  4*NIBBLES  nibble mask; each nibble is 0x0 or 0xF.
- out_data  out  4*NIBBLES  (src & mask) | (dst & ~mask).
- out_err  out  1  illegal code, P out of range, or clamped field.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk release behaviour is not required):
  - All stage valids = 0; out_valid = 0; out_mask = 0; out_data = 0; out_err = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
  - Reset mid-operation discards in-flight transactions; no partial output.
- Pipeline, two register stages:
  - S1: decodes field code to (start, last, err) and registers it with dst/src.
  - S2: builds the mask, merges, and registers out_*.
  - Latency is 2 cycles from accept to out_valid when out_ready is held high.
  - Throughput is 1 per cycle.
- Handshake:
  - Each stage advances when its successor is empty or draining that cycle: s2_adv = !out_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv.
  - in_ready must not combinationally depend on in_valid.
  - Outputs stay stable while out_valid && !out_ready.
  - Order is preserved; no transaction is dropped or duplicated.
- Field codes (start..last, inclusive nibble indices):
  - 0 P = p..p
  - 1 WP = 0..p
  - 2 XS = 2..2
  - 3 X = 0..2
  - 4 S = N-1..N-1
  - 5 M = 3..N-2
  - 6 B = 0..1
  - 7 W = 0..N-1
  - 8 A = 0..4
  - 9 EXPLICIT = start..(start+len)
  - 10-15 are illegal: mask = 0, data = dst, err = 1.
- P range: in_p >= NIBBLES with code 0 or 1 -> mask = 0, data = dst, err = 1.
- Explicit field arithmetic:
  - end = start + len, computed PW+1 bits wide.
  - If end >= NIBBLES and WRAP_EN = 1: nibbles start..N-1 plus 0..(end-N) are set; err = 0.
  - If end >= NIBBLES and WRAP_EN = 0: last = N-1; err = 1.
  - start >= NIBBLES -> mask = 0, data = dst, err = 1.
  - len = NIBBLES-1 with wrap -> full mask regardless of start.
- Mask construction:
  - Non-wrapping: nibble i is set iff start <= i <= last.
  - Wrapping: nibble i is set iff i >= start || i <= last.
  - Each mask bit expands to a full 4-bit nibble.

Decomposition:
- Package saturn_field_pkg holds:
  - Field-code localparams FLD_P..FLD_EXPLICIT.
  - A decode function code -> (start, last, wrap, err), parametrised by NIBBLES.
- Sub-module saturn_nibble_mask, combinational, NIBBLES parameter:
  - Inputs: start, last, wrap.
  - Output: 4*NIBBLES mask.
  - Instantiated in S2.
- The handshake/pipeline lives in the top module.

Test Plan:
- NIBBLES = 16, out_ready = 1, code 7 (W), dst = 0, src = FFFF_FFFF_FFFF_FFFF -> 2 cycles later: mask = FFFF_FFFF_FFFF_FFFF, data = FFFF_FFFF_FFFF_FFFF, err = 0.
- Code 1 (WP), p = 5, dst = 1111_1111_1111_1111, src = AAAA_AAAA_AAAA_AAAA -> mask = 0000_0000_00FF_FFFF, data = 1111_1111_11AA_AAAA.
- Code 9, start = 14, len = 3, WRAP_EN = 1 -> mask = FF00_0000_0000_00FF, err = 0.
- Same stimulus with WRAP_EN = 0 -> mask = FF00_0000_0000_0000, err = 1.
- Code 12 with dst = 1234_5678_9ABC_DEF0 -> mask = 0, data = 1234_5678_9ABC_DEF0, err = 1.
- Backpressure: issue codes 2, 3, 6 back-to-back with out_ready = 0.
  - in_ready drops after 2 accepts; out_* stay stable.
  - Then raise out_ready -> masks 0000_0000_0000_0F00, 0000_0000_0000_0FFF, 0000_0000_0000_00FF in order, one per cycle.
  - Third request is accepted as the pipeline drains.
- Reset: assert rst_n = 0 with 2 transactions in flight -> out_valid = 0 immediately; after release, no stale output appears and in_ready = 1.
